// File: rtl/serial_pkg.sv
// Shared serial-link definitions: FSM states, line levels and default frame geometry.
package serial_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset to a chosen level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Oversampling asynchronous serial receiver: start/data/stop framing, held
// character flag with read acknowledge, framing-error and overrun status.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 serial_in,
  input  logic                 read_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 character_received,
  output logic                 framing_error,
  output logic                 overrun,
  output state_t               fsm_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  state_t               state, state_next;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 line;
  logic                 tick_clr, tick_inc, bit_clr, bit_inc, shift_en;
  logic                 frame_good, frame_bad;

  sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (line)
  );

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (sample_tick) begin
      case (state)
        IDLE:      if (line == START_LEVEL) state_next = START;
        START:     if (tick_cnt == HALF_LAST) state_next = (line == START_LEVEL) ? DATA : IDLE;
        DATA:      if (tick_cnt == FULL_LAST && bit_cnt == LAST_BIT) state_next = STOP;
        STOP:      if (tick_cnt == FULL_LAST) state_next = (line == STOP_LEVEL) ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (line == IDLE_LEVEL) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Control strobes; each one is qualified by sample_tick so a held-off tick freezes everything.
  always_comb begin
    tick_clr   = 1'b0;
    tick_inc   = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (sample_tick) begin
      case (state)
        IDLE: begin
          tick_clr = 1'b1;
          bit_clr  = 1'b1;
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_clr = 1'b1;
            bit_inc  = 1'b1;
            shift_en = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            tick_clr   = 1'b1;
            frame_good = (line == STOP_LEVEL);
            frame_bad  = (line != STOP_LEVEL);
          end else begin
            tick_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (tick_clr)      tick_cnt <= '0;
      else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;
      if (bit_clr)       bit_cnt <= '0;
      else if (bit_inc)  bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)      shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
    end
  end

  // A completing good frame takes priority over a simultaneous read_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out           <= '0;
      character_received <= 1'b0;
      framing_error      <= 1'b0;
      overrun            <= 1'b0;
    end else if (frame_good) begin
      data_out           <= shift_reg;
      character_received <= 1'b1;
      framing_error      <= 1'b0;
      if (character_received && !read_ack) overrun <= 1'b1;
      else if (read_ack)                   overrun <= 1'b0;
    end else begin
      if (frame_bad) framing_error <= 1'b1;
      if (read_ack) begin
        character_received <= 1'b0;
        overrun            <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Receive end of the lab serial link; the counterpart of the transmitter that takes data_in/load/transmit_enable and drives serial data.
- Recovers 8-bit characters from the asynchronous serial line by oversampling, and presents each character on a parallel bus with a character_received flag.
- The flag is held until the consumer acknowledges it; the consumer is the top-level FSM or the microprocessor PIO.
- Runs on one system clock; bit timing comes from a sample-tick enable equivalent to the transmitter's minor clock.

Parameters:
OVERSAMPLE, 16, sample ticks per bit period (major/minor clock ratio); power of two, >= 4
DATA_BITS, 8, data bits per frame

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
sample_tick  input  1  one-clk-wide enable at oversample rate; all timing counts these
serial_in  input  1  serial line, asynchronous to clk, idle high
read_ack  input  1  one-clk pulse from consumer: character taken
data_out  output  DATA_BITS  last good character received
character_received  output  1  high while an unacknowledged character is in data_out
framing_error  output  1  high if the most recent frame had a low stop bit
overrun  output  1  high if a character was overwritten before read_ack

Behaviour:
- Frame format: idle 1; start bit 0; DATA_BITS data bits LSB first; one stop bit 1.
- Synchronizer: serial_in passes through 2 flops on clk. All decisions use the synchronized value, which lags the pin by 2 clk.
- Reset (rst=0, asynchronous):
  - data_out=0, character_received=0, framing_error=0, overrun=0.
  - FSM=IDLE, counters=0, shift register=0, synchronizer flops=1.
- Counters advance only on clk edges where sample_tick=1: tick counter (clog2(OVERSAMPLE) bits) and bit counter (clog2(DATA_BITS+1) bits).
- IDLE:
  - On a tick with line=0: go to START with tick counter=0.
- START:
  - Count to OVERSAMPLE/2-1 ticks (mid start bit), then sample.
  - Line=0: go to DATA, tick counter=0, bit counter=0.
  - Line=1: glitch; go to IDLE, no flags change.
- DATA:
  - Every OVERSAMPLE ticks, sample the line and shift it in at the MSB (shift right).
  - After DATA_BITS samples, go to STOP.
- STOP:
  - After OVERSAMPLE ticks, sample the line.
  - Line=1: data_out<=shift register, character_received<=1, framing_error<=0. If character_received was already 1 and no read_ack this cycle, overrun<=1. Go to IDLE.
  - Line=0: framing_error<=1, data_out and character_received unchanged. Go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until a tick sees line=1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
- Latency: flags update on the same clk edge as the stop-bit mid sample, about DATA_BITS+1.5 bit periods after the start edge, plus 2 clk of synchronizer delay.
- read_ack:
  - Clears character_received and overrun on the next clk edge.
  - If read_ack coincides with a good-frame completion, the new character wins: character_received stays 1, data_out takes the new value, overrun is not set.
  - read_ack does not clear framing_error; the next good frame clears it.
  - read_ack while character_received=0 has no effect.
- sample_tick held 0: FSM freezes in its current state; no time-out.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values immediately.

Decomposition:
- Shared package (serial_pkg): FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH); frame constants (START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1); default OVERSAMPLE/DATA_BITS, shared with the transmitter.
- Sub-module: sync_2ff, a 1-bit two-flop synchronizer with async active-low reset to 1 and a reset-value parameter. It is reusable for the KEY inputs.

Test Plan:
- Frame 0x74 ('t') at OVERSAMPLE=16, ticks every 4 clk -> data_out=0x74, character_received=1, framing_error=0, overrun=0; read_ack -> character_received=0 next clk.
- Send 't','e','s','t' (0x74, 0x65, 0x73, 0x74) back-to-back, with read_ack after each flag -> four flag assertions, data_out matches in order, no overrun.
- Line low for 5 ticks, then high (glitch) -> FSM returns to IDLE, all outputs unchanged; a following 0x65 frame is received correctly.
- Frame 0x55 with stop bit 0, line held low for 40 ticks -> framing_error=1, character_received stays 0, no new frame starts until the line goes high; a next good 0x73 clears framing_error.
- Frames 0x11 then 0x22 with no read_ack -> data_out=0x22, overrun=1; read_ack clears both flags. Repeat with read_ack on the completion cycle of 0x22 -> character_received=1, overrun=0.
- Assert rst during data bit 4 of a 0x74 frame -> all outputs 0 asynchronously; after release, the next full 0x65 frame is received correctly.
